in_skew_4x4_2dw: RTL and testbench

- Downstream neighbour of the 4x4 input row buffer; feeds the west edge of the 4x4 systolic array.
- On start, drives the buffer's read line for exactly m cycles and captures one 4-lane row per cycle.
- Delays lane k by k cycles to form the diagonal wavefront; inactive lane slots carry zero.
- Flushes the skew pipeline, then pulses done.

---
 rtl/in_skew_4x4_2dw_pkg.sv | 16 +
 rtl/in_skew_4x4_2dw_skew_delay_line.sv | 39 +++
 rtl/in_skew_4x4_2dw.sv | 117 +++++++++++
 tb/tb_in_skew_4x4_2dw.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/in_skew_4x4_2dw_pkg.sv
// Shared constants and FSM encoding for the 4x4 systolic-array input skew block.
package in_skew_4x4_2dw_pkg;

  localparam int SKEW_DATA_WIDTH = 16;
  localparam int SKEW_D_2_W      = 2 * SKEW_DATA_WIDTH;
  localparam int SKEW_N          = 4;
  localparam int SKEW_M          = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } skew_state_e;

endpackage

// File: rtl/in_skew_4x4_2dw_skew_delay_line.sv
// Valid-qualified shift register of DEPTH stages; output data reads zero
// whenever the last stage holds no valid word.
module skew_delay_line #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid_i;
      if (in_valid_i) begin
        data_q[0] <= in_data_i;
      end
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign out_valid_o = valid_q[DEPTH-1];
  assign out_data_o  = valid_q[DEPTH-1] ? data_q[DEPTH-1] : '0;

endmodule

// File: rtl/in_skew_4x4_2dw.sv
// Reads one m-row tile from the input row buffer and skews lane k by k cycles
// to build the diagonal wavefront for the west edge of the 4x4 array.
module in_skew_4x4_2dw
  import in_skew_4x4_2dw_pkg::*;
#(
  parameter int DATA_WIDTH = SKEW_DATA_WIDTH,
  parameter int D_2_W      = 2 * DATA_WIDTH,
  parameter int n          = SKEW_N,
  parameter int m          = SKEW_M
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             buf_empty,
  input  logic [D_2_W-1:0] in0,
  input  logic [D_2_W-1:0] in1,
  input  logic [D_2_W-1:0] in2,
  input  logic [D_2_W-1:0] in3,
  output logic             buf_read,
  output logic [D_2_W-1:0] out0,
  output logic [D_2_W-1:0] out1,
  output logic [D_2_W-1:0] out2,
  output logic [D_2_W-1:0] out3,
  output logic [3:0]       lane_valid,
  output logic             busy,
  output logic             done
);

  localparam int RD_W = $clog2(m + 1);
  localparam int FL_W = $clog2(n + 1);

  skew_state_e     state_q, state_d;
  logic [RD_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [FL_W-1:0] fl_cnt_q, fl_cnt_d;
  logic            cap_v_q;

  logic [D_2_W-1:0] lane_in  [4];
  logic [D_2_W-1:0] lane_out [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rd_cnt_q <= '0;
      fl_cnt_q <= '0;
      cap_v_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      fl_cnt_q <= fl_cnt_d;
      cap_v_q  <= buf_read;
    end
  end

  // An empty buffer during READ cuts the tile short; rows already read still drain.
  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    fl_cnt_d = fl_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start && !buf_empty) begin
          state_d  = READ;
          rd_cnt_d = '0;
        end
      end
      READ: begin
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (buf_empty || rd_cnt_q == RD_W'(m - 1)) begin
          state_d  = FLUSH;
          fl_cnt_d = '0;
        end
      end
      FLUSH: begin
        fl_cnt_d = fl_cnt_q + 1'b1;
        if (fl_cnt_q == FL_W'(n)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign buf_read = (state_q == READ);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

  assign lane_in[0] = in0;
  assign lane_in[1] = in1;
  assign lane_in[2] = in2;
  assign lane_in[3] = in3;

  // Lane k sees k extra register stages beyond the capture stage.
  for (genvar k = 0; k < 4; k++) begin : g_lane
    skew_delay_line #(
      .WIDTH(D_2_W),
      .DEPTH(k + 1)
    ) u_delay (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid_i (cap_v_q),
      .in_data_i  (lane_in[k]),
      .out_valid_o(lane_valid[k]),
      .out_data_o (lane_out[k])
    );
  end

  assign out0 = lane_out[0];
  assign out1 = lane_out[1];
  assign out2 = lane_out[2];
  assign out3 = lane_out[3];

endmodule

// File: tb/tb_in_skew_4x4_2dw.sv
// Self-checking bench for in_skew_4x4_2dw: a registered row-buffer model feeds
// the block and every output is compared each cycle against the skew schedule.
module tb_in_skew_4x4_2dw;

  localparam int M = 7;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         bufEmpty;
  logic [W-1:0] in0, in1, in2, in3;
  logic         bufRead;
  logic [W-1:0] out0, out1, out2, out3;
  logic [3:0]   laneValid;
  logic         busy;
  logic         done;

  logic [W-1:0] outs [4];
  logic [W-1:0] rowMem [256][4];
  logic [7:0]   rdIdx = 8'd0;

  int total = 0;
  int bad   = 0;

  in_skew_4x4_2dw dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .buf_empty (bufEmpty),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .buf_read  (bufRead),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .lane_valid(laneValid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  assign outs[0] = out0;
  assign outs[1] = out1;
  assign outs[2] = out2;
  assign outs[3] = out3;

  // Row buffer model: a read in one cycle presents that row on the next cycle.
  always @(posedge clk) begin
    if (bufRead === 1'b1) begin
      in0   <= rowMem[rdIdx][0];
      in1   <= rowMem[rdIdx][1];
      in2   <= rowMem[rdIdx][2];
      in3   <= rowMem[rdIdx][3];
      rdIdx <= rdIdx + 8'd1;
    end
  end

  task automatic checkIdle(input string tag);
    total++;
    if ({bufRead, busy, done, laneValid} !== 7'b0) begin
      bad++;
      $display("[TB] FAIL %s ctrl got=%b want=0000000", tag, {bufRead, busy, done, laneValid});
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (outs[k] !== '0) begin
        bad++;
        $display("[TB] FAIL %s out%0d got=%h want=0", tag, k, outs[k]);
      end
    end
  endtask

  // One tile from the cycle before t0; returns at the start of cycle t0+R+6
  // (the first IDLE cycle after done), or after an abort by reset.
  task automatic runTile(input int emptyAt, input int startAt, input int abortAt, input string tag);
    int R;
    int base;
    R = (emptyAt >= 0 && emptyAt < M) ? emptyAt + 1 : M;
    start = 1'b1;
    @(negedge clk);
    checkIdle({tag, "_pre"});
    @(posedge clk);
    #1;
    base = int'(rdIdx);
    start = 1'b0;
    for (int j = 0; j <= R + 5; j++) begin
      if (j == emptyAt) bufEmpty = 1'b1;
      start = (j == startAt);
      @(negedge clk);
      total++;
      if (bufRead !== (j < R)) begin
        bad++;
        $display("[TB] FAIL %s buf_read j=%0d got=%b want=%b", tag, j, bufRead, (j < R));
      end
      total++;
      if (busy !== 1'b1) begin
        bad++;
        $display("[TB] FAIL %s busy j=%0d got=%b want=1", tag, j, busy);
      end
      total++;
      if (done !== (j == R + 5)) begin
        bad++;
        $display("[TB] FAIL %s done j=%0d got=%b want=%b", tag, j, done, (j == R + 5));
      end
      for (int k = 0; k < 4; k++) begin
        int r;
        logic v;
        logic [W-1:0] e;
        r = j - 2 - k;
        v = (r >= 0 && r < R);
        e = v ? rowMem[8'(base + r)][k] : '0;
        total++;
        if (laneValid[k] !== v) begin
          bad++;
          $display("[TB] FAIL %s lane_valid%0d j=%0d got=%b want=%b", tag, k, j, laneValid[k], v);
        end
        total++;
        if (outs[k] !== e) begin
          bad++;
          $display("[TB] FAIL %s out%0d j=%0d got=%h want=%h", tag, k, j, outs[k], e);
        end
      end
      if (j == abortAt) begin
        rst_n = 1'b0;
        #1;
        checkIdle({tag, "_abort"});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start = 1'b0;
        bufEmpty = 1'b0;
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          checkIdle({tag, "_after_abort"});
          @(posedge clk);
          #1;
        end
        return;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    bufEmpty = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    start = 1'b0;
    bufEmpty = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    checkIdle("reset_async");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkIdle("reset_idle");
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_nominal();
    runTile(-1, -1, -1, "nominal");
  endtask

  task automatic test_empty_start();
    bufEmpty = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkIdle("empty_start");
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    bufEmpty = 1'b0;
    runTile(-1, -1, -1, "after_empty");
  endtask

  task automatic test_early_empty();
    runTile(2, -1, -1, "early_empty");
  endtask

  task automatic test_reset_mid_flush();
    runTile(-1, -1, M + 2, "abort_flush");
    runTile(-1, -1, -1, "after_abort_tile");
  endtask

  task automatic test_back_to_back();
    runTile(-1, 1, -1, "start_while_busy");
    runTile(-1, -1, -1, "back_to_back");
  endtask

  initial begin
    for (int r = 0; r < 256; r++) begin
      for (int k = 0; k < 4; k++) begin
        rowMem[r][k] = (r < M) ? W'(r * 4 + k) : $urandom;
      end
    end
    test_reset();
    test_nominal();
    test_empty_start();
    test_early_empty();
    test_reset_mid_flush();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
